// File: rtl/rom_fetch_sequencer.sv
// CPU-side initiator for the program ROM nibble-serial fetch: 8-phase cycle counter,
// program counter, nibble capture and single/double-word instruction assembly.
module rom_fetch_sequencer #(
    parameter logic [11:0] RESET_PC      = 12'h000,
    parameter logic [15:0] TWO_WORD_MASK = 16'b0000_0000_1011_0110
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hold,
    output logic [2:0]  cycle,
    output logic        sync,
    output logic [11:0] rom_addr,
    input  logic [3:0]  rom_nibble,
    input  logic        jump_en,
    input  logic [11:0] jump_addr,
    output logic        instr_valid,
    output logic [7:0]  instr_word1,
    output logic [7:0]  instr_word2,
    output logic        instr_two,
    output logic [11:0] instr_pc
);

    typedef enum logic [2:0] {
        A1 = 3'd0, A2 = 3'd1, A3 = 3'd2, M1 = 3'd3,
        M2 = 3'd4, X1 = 3'd5, X2 = 3'd6, X3 = 3'd7
    } phase_t;

    phase_t      phase_q, phase_d;
    logic [11:0] pc;
    logic [3:0]  opr_nib;
    logic        pending;
    logic [7:0]  word1_hold;
    logic [11:0] pc_hold;
    logic [7:0]  fetched;
    logic        is_two;

    assign cycle = phase_q;
    assign sync  = (phase_q == X3);

    // FIM with an odd OPA is SRC, which is single-word.
    assign fetched = {opr_nib, rom_nibble};
    assign is_two  = TWO_WORD_MASK[fetched[7:4]] && !((fetched[7:4] == 4'h2) && fetched[0]);

    always_comb begin
        // NOTE: default assigned first so no path leaves phase_d unassigned (no latch).
        phase_d = phase_t'(phase_q + 3'd1);
        if (phase_q == X3 && hold)
            phase_d = X3;
    end

    // NOTE: all state updates are non-blocking so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q     <= A1;
            pc          <= RESET_PC;
            rom_addr    <= RESET_PC;
            opr_nib     <= 4'h0;
            pending     <= 1'b0;
            word1_hold  <= 8'h00;
            pc_hold     <= 12'h000;
            instr_valid <= 1'b0;
            instr_word1 <= 8'h00;
            instr_word2 <= 8'h00;
            instr_two   <= 1'b0;
            instr_pc    <= 12'h000;
        end else begin
            phase_q     <= phase_d;
            instr_valid <= 1'b0;
            case (phase_q)
                M1: opr_nib <= rom_nibble;
                M2: begin
                    pc <= pc + 12'd1;
                    // Outputs registered here appear during X1.
                    if (pending) begin
                        instr_valid <= 1'b1;
                        instr_word1 <= word1_hold;
                        instr_word2 <= fetched;
                        instr_two   <= 1'b1;
                        instr_pc    <= pc_hold;
                        pending     <= 1'b0;
                    end else if (is_two) begin
                        word1_hold <= fetched;
                        pc_hold    <= rom_addr;
                        pending    <= 1'b1;
                    end else begin
                        instr_valid <= 1'b1;
                        instr_word1 <= fetched;
                        instr_word2 <= 8'h00;
                        instr_two   <= 1'b0;
                        instr_pc    <= rom_addr;
                    end
                end
                X3: begin
                    if (jump_en) begin
                        pc      <= jump_addr;
                        pending <= 1'b0;
                    end
                    if (!hold)
                        rom_addr <= jump_en ? jump_addr : pc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Self-checking bench: ROM emulator, instruction-level reference model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_rom_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        hold = 1'b0;
    logic [2:0]  cycle;
    logic        sync;
    logic [11:0] rom_addr;
    logic [3:0]  rom_nibble;
    logic        jump_en = 1'b0;
    logic [11:0] jump_addr = 12'h000;
    logic        instr_valid;
    logic [7:0]  instr_word1;
    logic [7:0]  instr_word2;
    logic        instr_two;
    logic [11:0] instr_pc;

    int checks = 0;
    int errors = 0;
    int clk_n  = 0;
    bit check_en = 1'b0;

    logic [7:0] rom [4096];

    rom_fetch_sequencer dut (
        .clk(clk), .rst(rst), .hold(hold), .cycle(cycle), .sync(sync),
        .rom_addr(rom_addr), .rom_nibble(rom_nibble), .jump_en(jump_en),
        .jump_addr(jump_addr), .instr_valid(instr_valid), .instr_word1(instr_word1),
        .instr_word2(instr_word2), .instr_two(instr_two), .instr_pc(instr_pc)
    );

    always #5 clk = ~clk;

    // ROM drives junk outside the two data phases so a mistimed capture shows up.
    always_comb begin
        logic [7:0] b;
        b = rom[rom_addr];
        if (cycle == 3'd3)      rom_nibble = b[7:4];
        else if (cycle == 3'd4) rom_nibble = b[3:0];
        else                    rom_nibble = 4'h6;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at clock %0d: got %h expected %h", name, clk_n, act, exp);
        end
    endtask

    // Reference model: tracks the clock position inside an instruction cycle and
    // delivers whole ROM bytes; two-word opcodes listed explicitly.
    function automatic bit opens_two_word(input logic [7:0] b);
        case (b[7:4])
            4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
            4'h2:                   return ~b[0];
            default:                return 1'b0;
        endcase
    endfunction

    int          m_pos;
    logic [11:0] m_pc, m_addr, m_first_pc, m_ipc;
    logic [7:0]  m_first, m_w1, m_w2;
    bit          m_pend, m_valid, m_two;

    always @(posedge clk) begin
        if (rst) begin
            clk_n = 0;
            m_pos = 0; m_pc = 12'h000; m_addr = 12'h000; m_pend = 0;
            m_valid = 0; m_w1 = 0; m_w2 = 0; m_two = 0; m_ipc = 0;
            m_first = 0; m_first_pc = 0;
        end else begin
            clk_n++;
            m_valid = 0;
            if (m_pos == 4) begin
                m_pc = m_pc + 1;
                if (m_pend) begin
                    m_valid = 1; m_w1 = m_first; m_w2 = rom[m_addr];
                    m_two = 1; m_ipc = m_first_pc; m_pend = 0;
                end else if (opens_two_word(rom[m_addr])) begin
                    m_pend = 1; m_first = rom[m_addr]; m_first_pc = m_addr;
                end else begin
                    m_valid = 1; m_w1 = rom[m_addr]; m_w2 = 0; m_two = 0; m_ipc = m_addr;
                end
            end
            if (m_pos == 7) begin
                if (jump_en) begin
                    m_pc = jump_addr;
                    m_pend = 0;
                end
                if (!hold) begin
                    m_addr = m_pc;
                    m_pos = 0;
                end
            end else begin
                m_pos++;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("cycle", 32'(cycle), 32'(m_pos));
            check("sync", 32'(sync), 32'(m_pos == 7));
            check("rom_addr", 32'(rom_addr), 32'(m_addr));
            check("instr_valid", 32'(instr_valid), 32'(m_valid));
            check("instr_word1", 32'(instr_word1), 32'(m_w1));
            check("instr_word2", 32'(instr_word2), 32'(m_w2));
            check("instr_two", 32'(instr_two), 32'(m_two));
            check("instr_pc", 32'(instr_pc), 32'(m_ipc));
        end
    end

    task automatic wait_clk(input int k);
        for (int i = 0; i < 200 && clk_n != k; i++)
            @(negedge clk);
        if (clk_n != k) check("wait_clk_timeout", 32'(clk_n), 32'(k));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic fill_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'hD3;
    endtask

    initial begin
        fill_rom();
        @(negedge clk);

        // Single-word stream
        rom[0] = 8'h00; rom[1] = 8'h85; rom[2] = 8'h97;
        do_reset();
        check_en = 1'b1;
        check("rst_cycle", 32'(cycle), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_sync", 32'(sync), 32'd0);
        check("rst_addr", 32'(rom_addr), 32'h000);
        wait_clk(5);
        check("s1_valid", 32'(instr_valid), 32'd1);
        check("s1_w1", 32'(instr_word1), 32'h00);
        wait_clk(6);
        check("s1_pulse_end", 32'(instr_valid), 32'd0);
        wait_clk(13);
        check("s2_w1", 32'(instr_word1), 32'h85);
        check("s2_pc", 32'(instr_pc), 32'h001);
        wait_clk(21);
        check("s3_w1", 32'(instr_word1), 32'h97);
        check("s3_two", 32'(instr_two), 32'd0);

        // JUN two-word
        fill_rom(); rom[0] = 8'h40; rom[1] = 8'h5A;
        do_reset();
        wait_clk(5);
        check("jun_no_early", 32'(instr_valid), 32'd0);
        wait_clk(13);
        check("jun_valid", 32'(instr_valid), 32'd1);
        check("jun_w1", 32'(instr_word1), 32'h40);
        check("jun_w2", 32'(instr_word2), 32'h5A);
        check("jun_pc", 32'(instr_pc), 32'h000);
        wait_clk(16);
        check("jun_next_addr", 32'(rom_addr), 32'h002);

        // FIM vs SRC
        fill_rom(); rom[0] = 8'h22; rom[1] = 8'h7F;
        do_reset();
        wait_clk(5);
        check("fim_no_early", 32'(instr_valid), 32'd0);
        wait_clk(13);
        check("fim_two", 32'(instr_two), 32'd1);
        check("fim_w2", 32'(instr_word2), 32'h7F);
        rom[0] = 8'h23;
        do_reset();
        wait_clk(5);
        check("src_valid", 32'(instr_valid), 32'd1);
        check("src_two", 32'(instr_two), 32'd0);

        // Jumps, including into FFF and the wrap to 000
        fill_rom();
        do_reset();
        wait_clk(7); jump_en = 1'b1; jump_addr = 12'hABC;
        wait_clk(8); jump_en = 1'b0;
        check("jump_addr", 32'(rom_addr), 32'hABC);
        wait_clk(15); jump_en = 1'b1; jump_addr = 12'hFFF;
        wait_clk(16); jump_en = 1'b0;
        check("jump_fff", 32'(rom_addr), 32'hFFF);
        wait_clk(24);
        check("pc_wrap", 32'(rom_addr), 32'h000);

        // Jump while a two-word instruction is pending drops the first word
        fill_rom(); rom[0] = 8'h40; rom[12'h100] = 8'hD5;
        do_reset();
        wait_clk(7); jump_en = 1'b1; jump_addr = 12'h100;
        wait_clk(8); jump_en = 1'b0;
        wait_clk(13);
        check("jmp_pend_w1", 32'(instr_word1), 32'hD5);
        check("jmp_pend_two", 32'(instr_two), 32'd0);
        check("jmp_pend_pc", 32'(instr_pc), 32'h100);

        // Hold for three clocks at X3
        fill_rom();
        do_reset();
        wait_clk(7); hold = 1'b1;
        wait_clk(10); hold = 1'b0;
        check("hold_cycle", 32'(cycle), 32'd7);
        check("hold_sync", 32'(sync), 32'd1);
        check("hold_addr", 32'(rom_addr), 32'h000);
        wait_clk(11);
        check("hold_release", 32'(cycle), 32'd0);
        wait_clk(13);
        check("hold_no_early", 32'(instr_valid), 32'd0);
        wait_clk(16);
        check("hold_delayed", 32'(instr_valid), 32'd1);
        check("hold_pc", 32'(instr_pc), 32'h001);

        // Reset in M2 of the second word of a two-word fetch
        fill_rom(); rom[0] = 8'h40; rom[1] = 8'h5A;
        do_reset();
        wait_clk(12);
        do_reset();
        check("mid_rst_cycle", 32'(cycle), 32'd0);
        check("mid_rst_valid", 32'(instr_valid), 32'd0);
        check("mid_rst_addr", 32'(rom_addr), 32'h000);
        wait_clk(5);
        check("mid_rst_no_stale", 32'(instr_valid), 32'd0);
        wait_clk(13);
        check("mid_rst_refetch", 32'(instr_word2), 32'h5A);
        wait_clk(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
